// File: rtl/clfsr_stream_cipher.sv
// clfsr_stream_cipher: streaming pixel cipher. Each accepted pixel is XORed
// with a Galois-LFSR keystream and with the previous ciphertext (chaining).
// Output is registered one cycle after accept. Frame control covers
// IDLE/RUN/DRAIN/DONE with last-beat marking and a done pulse.
module clfsr_stream_cipher #(
  parameter int unsigned        DATA_W  = 8,
  parameter int unsigned        NUM_CH  = 3,
  parameter int unsigned        LFSR_W  = 32,
  parameter logic [LFSR_W-1:0]  TAPS    = LFSR_W'(32'h8020_0003),
  parameter int unsigned        NUM_PIX = 65536,
  parameter int unsigned        CNT_W   = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [LFSR_W-1:0]          seed,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [NUM_CH*DATA_W-1:0]   s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NUM_CH*DATA_W-1:0]   m_data,
  output logic                       m_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned PW = NUM_CH * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIX - 1);

  // The keystream slice for all channels must fit inside the LFSR state.
  generate
    if (PW > LFSR_W) begin : g_width_err
      $error("clfsr_stream_cipher: NUM_CH*DATA_W exceeds LFSR_W");
    end
    if (NUM_PIX < 1) begin : g_npix_err
      $error("clfsr_stream_cipher: NUM_PIX must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One Galois step: shift right, fold the taps in when bit 0 falls out.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    logic [LFSR_W-1:0] nxt;
    nxt = {1'b0, cur[LFSR_W-1:1]};
    if (cur[0]) begin
      nxt = nxt ^ TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  state_t              state_r;
  logic [LFSR_W-1:0]   lfsr_r;
  logic [PW-1:0]       chain_r;
  logic [CNT_W-1:0]    count_r;
  logic                mode_r;
  logic                m_valid_r;
  logic                m_last_r;
  logic [PW-1:0]       m_data_r;

  logic                s_ready_s;
  logic                accept_s;
  logic                take_s;
  logic                last_pix_s;
  logic [PW-1:0]       out_word_s;
  logic [PW-1:0]       chain_nxt_s;

  // Input handshake: accept only in RUN while the output slot is free or draining.
  always_comb begin
    if (state_r == ST_RUN) begin
      s_ready_s = !m_valid_r || m_ready;
    end else begin
      s_ready_s = 1'b0;
    end
    accept_s   = s_valid && s_ready_s;
    take_s     = m_valid_r && m_ready;
    last_pix_s = (count_r == LAST_CNT);
  end

  // Cipher word and next chain value; channels are independent bit slices so
  // one wide XOR covers every channel at once.
  always_comb begin
    out_word_s = s_data ^ lfsr_r[PW-1:0] ^ chain_r;
    if (mode_r) begin
      chain_nxt_s = s_data;
    end else begin
      chain_nxt_s = out_word_s;
    end
  end

  // Frame sequencing: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_r <= ST_RUN;
          else       state_r <= ST_IDLE;
        end
        ST_RUN: begin
          if (accept_s && last_pix_s) state_r <= ST_DRAIN;
          else                        state_r <= ST_RUN;
        end
        ST_DRAIN: begin
          if (take_s && m_last_r) state_r <= ST_DONE;
          else                    state_r <= ST_DRAIN;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Keystream, chain and pixel count: loaded at frame start, advanced only on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_r  <= {LFSR_W{1'b0}};
      chain_r <= {PW{1'b0}};
      count_r <= {CNT_W{1'b0}};
      mode_r  <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      // An all-zero seed would lock the LFSR, so substitute 1.
      lfsr_r  <= (seed == {LFSR_W{1'b0}}) ? LFSR_W'(1'b1) : seed;
      chain_r <= {PW{1'b0}};
      count_r <= {CNT_W{1'b0}};
      mode_r  <= mode;
    end else if (accept_s) begin
      lfsr_r  <= lfsr_step(lfsr_r);
      chain_r <= chain_nxt_s;
      count_r <= count_r + CNT_W'(1'b1);
      mode_r  <= mode_r;
    end else begin
      lfsr_r  <= lfsr_r;
      chain_r <= chain_r;
      count_r <= count_r;
      mode_r  <= mode_r;
    end
  end

  // Output register: loads on accept, empties on take, holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= {PW{1'b0}};
    end else if (accept_s) begin
      m_valid_r <= 1'b1;
      m_last_r  <= last_pix_s;
      m_data_r  <= out_word_s;
    end else if (take_s) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= m_data_r;
    end else begin
      m_valid_r <= m_valid_r;
      m_last_r  <= m_last_r;
      m_data_r  <= m_data_r;
    end
  end

  assign s_ready = s_ready_s;
  assign m_valid = m_valid_r;
  assign m_last  = m_last_r;
  assign m_data  = m_data_r;
  assign busy    = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign done    = (state_r == ST_DONE);

endmodule
